// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad scanner:
//   - key code width
//   - active-low one-cold column drive patterns and an index-to-pattern helper
//   - stable-state FSM encoding (RELEASED / PRESSED)
//   - frame classification encoding (NONE / SINGLE(code) / MULTI)
//   - a saturating hit counter used by the frame classifier
// No ports; imported by keypad_scanner and keypad_debounce.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package keypad_pkg;

    localparam int KEY_CODE_W = 4;

    // Column drive patterns, one column low at a time.
    localparam logic [3:0] COL_PAT_0 = 4'b1110;
    localparam logic [3:0] COL_PAT_1 = 4'b1101;
    localparam logic [3:0] COL_PAT_2 = 4'b1011;
    localparam logic [3:0] COL_PAT_3 = 4'b0111;

    // Stable-state FSM encoding.
    localparam logic [0:0] ST_RELEASED = 1'b0;
    localparam logic [0:0] ST_PRESSED  = 1'b1;

    // Frame classification.
    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_MULTI  = 2'd2
    } cls_kind_t;

    typedef struct packed {
        cls_kind_t              kind;
        logic [KEY_CODE_W-1:0]  code;
    } cls_t;

    // Column index to drive pattern.
    function automatic logic [3:0] col_pattern(input logic [1:0] idx);
        logic [3:0] pat;
        case (idx)
            2'd0:    pat = COL_PAT_0;
            2'd1:    pat = COL_PAT_1;
            2'd2:    pat = COL_PAT_2;
            2'd3:    pat = COL_PAT_3;
            default: pat = COL_PAT_0;
        endcase
        return pat;
    endfunction

    // Number of active intersections, saturated at 2 (0, 1, or "2 or more").
    function automatic logic [1:0] hit_count_sat(input logic [15:0] hits);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, hits[i]};
        end
        if (n >= 5'd2) begin
            return 2'd2;
        end else begin
            return n[1:0];
        end
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// -----------------------------------------------------------------------------
// keypad_debounce
// Frame-level debouncer and stable-state FSM for the keypad scanner.
// Consumes one classification per scan frame, tracks a candidate and an
// agreement count, and moves the stable state once the candidate has been
// seen in DEBOUNCE_FRAMES consecutive usable frames. MULTI frames are ignored.
//
// Optional feature macro: KEYPAD_AUTOREPEAT_EN
//   When defined, a frame counter runs while PRESSED and re-pulses o_key_valid
//   every REPEAT_FRAMES frames without a state change.
//
// Ports:
//   clock        board clock
//   reset        asynchronous active-high reset
//   i_cls_valid  one-cycle strobe: i_cls holds a fresh frame classification
//   i_cls        frame classification (kind + code)
//   o_key_code   code of the last accepted key
//   o_key_valid  one-cycle strobe on accepted press / key change / repeat
//   o_key_held   high while a debounced key is down
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_cls_valid,
    input  cls_t                  i_cls,
    output logic [KEY_CODE_W-1:0] o_key_code,
    output logic                  o_key_valid,
    output logic                  o_key_held
);

    localparam int                AGREE_W   = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [AGREE_W-1:0] AGREE_MAX = AGREE_W'(DEBOUNCE_FRAMES);

    // Candidate: r_cand_key=0 means NONE, otherwise SINGLE(r_cand_code).
    logic                  r_cand_key;
    logic [KEY_CODE_W-1:0] r_cand_code;
    logic [AGREE_W-1:0]    r_agree;
    logic [0:0]            r_state;
    logic [KEY_CODE_W-1:0] r_key_code;
    logic                  r_key_valid;
    logic                  r_key_held;

    logic                  w_usable;
    logic                  w_cls_key;
    logic                  w_match;
    logic                  w_cand_key_nxt;
    logic [KEY_CODE_W-1:0] w_cand_code_nxt;
    logic [AGREE_W-1:0]    w_agree_nxt;
    logic                  w_stable;
    logic [0:0]            w_state_nxt;
    logic [KEY_CODE_W-1:0] w_code_nxt;
    logic                  w_held_nxt;
    logic                  w_press;
    logic                  w_release;
    logic                  w_rpt_fire;

    assign w_usable  = i_cls_valid && (i_cls.kind != CLS_MULTI);
    assign w_cls_key = (i_cls.kind == CLS_SINGLE);
    // The code field is irrelevant when both sides are NONE.
    assign w_match   = (w_cls_key == r_cand_key) &&
                       (!w_cls_key || (i_cls.code == r_cand_code));

    // Candidate / agreement-count update for the incoming frame.
    always_comb begin
        w_cand_key_nxt  = r_cand_key;
        w_cand_code_nxt = r_cand_code;
        w_agree_nxt     = r_agree;
        if (w_usable) begin
            if (w_match) begin
                if (r_agree == AGREE_MAX) begin
                    w_agree_nxt = AGREE_MAX;
                end else begin
                    w_agree_nxt = r_agree + AGREE_W'(1);
                end
            end else begin
                w_cand_key_nxt  = w_cls_key;
                w_cand_code_nxt = i_cls.code;
                w_agree_nxt     = AGREE_W'(1);
            end
        end else begin
            w_agree_nxt = r_agree;
        end
    end

    // The candidate is stable on the frame that brings its count to the limit
    // (and on every later agreeing frame, which the FSM sees as "no change").
    assign w_stable = w_usable && (w_agree_nxt == AGREE_MAX);

    // Stable-state FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_key_code;
        w_held_nxt  = r_key_held;
        w_press     = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_RELEASED: begin
                if (w_stable && w_cand_key_nxt) begin
                    w_state_nxt = ST_PRESSED;
                    w_code_nxt  = w_cand_code_nxt;
                    w_held_nxt  = 1'b1;
                    w_press     = 1'b1;
                end else begin
                    w_state_nxt = ST_RELEASED;
                end
            end
            ST_PRESSED: begin
                if (w_stable && w_cand_key_nxt && (w_cand_code_nxt != r_key_code)) begin
                    w_code_nxt = w_cand_code_nxt;
                    w_press    = 1'b1;
                end else if (w_stable && !w_cand_key_nxt) begin
                    // Release keeps the last code visible.
                    w_state_nxt = ST_RELEASED;
                    w_held_nxt  = 1'b0;
                    w_release   = 1'b1;
                end else begin
                    w_state_nxt = ST_PRESSED;
                end
            end
            default: begin
                w_state_nxt = ST_RELEASED;
                w_held_nxt  = 1'b0;
            end
        endcase
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int                RPT_W    = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
    localparam logic [RPT_W-1:0]  RPT_LAST = RPT_W'(REPEAT_FRAMES - 1);

    logic [RPT_W-1:0] r_rpt_cnt;

    // A repeat fires on the frame completing a full period; any transition wins.
    assign w_rpt_fire = i_cls_valid && (r_state == ST_PRESSED) &&
                        !w_press && !w_release && (r_rpt_cnt == RPT_LAST);

    // Frames-since-transition counter while a key is held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rpt_cnt <= '0;
        end else if (w_press || w_release) begin
            r_rpt_cnt <= '0;
        end else if (i_cls_valid && (r_state == ST_PRESSED)) begin
            if (w_rpt_fire) begin
                r_rpt_cnt <= '0;
            end else begin
                r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
            end
        end else begin
            r_rpt_cnt <= r_rpt_cnt;
        end
    end
`else
    assign w_rpt_fire = 1'b0;
`endif

    // Debounce and FSM state registers; outputs are registered here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cand_key  <= 1'b0;
            r_cand_code <= '0;
            r_agree     <= '0;
            r_state     <= ST_RELEASED;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_cand_key  <= w_cand_key_nxt;
            r_cand_code <= w_cand_code_nxt;
            r_agree     <= w_agree_nxt;
            r_state     <= w_state_nxt;
            r_key_code  <= w_code_nxt;
            r_key_valid <= w_press || w_rpt_fire;
            r_key_held  <= w_held_nxt;
        end
    end

    assign o_key_code  = r_key_code;
    assign o_key_valid = r_key_valid;
    assign o_key_held  = r_key_held;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// 4x4 matrix keypad scanner. Drives one column low at a time for SCAN_DIV
// cycles, samples the synchronized rows at the end of each dwell, classifies
// each 4-column frame (NONE / SINGLE / MULTI) and hands the classification to
// keypad_debounce, which produces the key outputs.
//
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (auto-repeat in keypad_debounce)
//
// Ports:
//   clock      board clock (only clock)
//   reset      asynchronous active-high reset
//   row_in     keypad rows, active-low, asynchronous to clock
//   col_out    column drive, active-low one-cold
//   key_code   last accepted key, row_index*4 + col_index
//   key_valid  one-cycle strobe per accepted press / key change / repeat
//   key_held   high while a debounced key is down
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            row_in,
    output logic [3:0]            col_out,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    output logic                  key_held
);

    localparam int                DWELL_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);

    logic [3:0]         r_row_meta;
    logic [3:0]         r_row_sync;
    logic [DWELL_W-1:0] r_dwell;
    logic [1:0]         r_col_idx;
    logic [3:0]         r_col_out;
    logic [15:0]        r_hits;
    logic               r_cls_valid;
    cls_t               r_cls;

    logic               w_dwell_end;
    logic               w_frame_end;
    logic [1:0]         w_col_idx_nxt;
    logic [15:0]        w_col_hits;
    logic [15:0]        w_hits_frame;
    logic [1:0]         w_hit_cnt;
    logic [3:0]         w_first_code;
    cls_t               w_cls;

    assign w_dwell_end   = (r_dwell == DWELL_LAST);
    assign w_frame_end   = w_dwell_end && (r_col_idx == 2'd3);
    assign w_col_idx_nxt = r_col_idx + 2'd1;

    // Two-flop synchronizer for the asynchronous row lines (idle high).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_row_meta <= 4'b1111;
            r_row_sync <= 4'b1111;
        end else begin
            r_row_meta <= row_in;
            r_row_sync <= r_row_meta;
        end
    end

    // Dwell counter and column sequencer; col_out is registered with the index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dwell   <= '0;
            r_col_idx <= 2'd0;
            r_col_out <= COL_PAT_0;
        end else if (w_dwell_end) begin
            r_dwell   <= '0;
            r_col_idx <= w_col_idx_nxt;
            r_col_out <= col_pattern(w_col_idx_nxt);
        end else begin
            r_dwell   <= r_dwell + DWELL_W'(1);
            r_col_idx <= r_col_idx;
            r_col_out <= r_col_out;
        end
    end

    // Map the current column's active rows onto their key-code bit positions.
    always_comb begin
        w_col_hits = 16'd0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if ((r_col_idx == 2'(c)) && !r_row_sync[r]) begin
                    w_col_hits[r*4 + c] = 1'b1;
                end else begin
                    w_col_hits[r*4 + c] = 1'b0;
                end
            end
        end
    end

    // Hits including the column being sampled right now.
    assign w_hits_frame = r_hits | w_col_hits;

    // Frame classifier; the code is only meaningful when exactly one hit exists.
    always_comb begin
        w_hit_cnt    = hit_count_sat(w_hits_frame);
        w_first_code = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w_hits_frame[i]) begin
                w_first_code = 4'(i);
            end else begin
                w_first_code = w_first_code;
            end
        end
        case (w_hit_cnt)
            2'd0: begin
                w_cls.kind = CLS_NONE;
                w_cls.code = 4'd0;
            end
            2'd1: begin
                w_cls.kind = CLS_SINGLE;
                w_cls.code = w_first_code;
            end
            default: begin
                w_cls.kind = CLS_MULTI;
                w_cls.code = 4'd0;
            end
        endcase
    end

    // Hit accumulator: gathers one sample per column, cleared at frame end.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hits <= 16'd0;
        end else if (w_frame_end) begin
            r_hits <= 16'd0;
        end else if (w_dwell_end) begin
            r_hits <= w_hits_frame;
        end else begin
            r_hits <= r_hits;
        end
    end

    // Registered frame classification with a one-cycle valid strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cls_valid <= 1'b0;
            r_cls       <= '{kind: CLS_NONE, code: 4'd0};
        end else if (w_frame_end) begin
            r_cls_valid <= 1'b1;
            r_cls       <= w_cls;
        end else begin
            r_cls_valid <= 1'b0;
            r_cls       <= r_cls;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
        .REPEAT_FRAMES   (REPEAT_FRAMES)
    ) u_debounce (
        .clock       (clock),
        .reset       (reset),
        .i_cls_valid (r_cls_valid),
        .i_cls       (r_cls),
        .o_key_code  (key_code),
        .o_key_valid (key_valid),
        .o_key_held  (key_held)
    );

    assign col_out = r_col_out;

endmodule
